mem_access_ctrl: RTL and testbench

Memory access sequencer between the CPU control unit and the main RAM. It accepts a one-cycle read or write request carrying the MAR address, drives a variable-latency ready-handshake memory port, and bounds each wait with a timeout. On a successful read it delivers the memory word to the MDR's `Mdatain` input and asserts the MDR's `read` select and `MDRin` load strobe for one cycle. It therefore sits directly upstream of the MDR on the memory side.

---
 rtl/mem_access_ctrl_if.sv | 22 ++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// RAM-side bus of the memory access sequencer: address/data, enables and ready handshake.
interface mem_access_ctrl_if #(
    parameter int wordSize = 32,
    parameter int addrSize = 9
);
    logic [addrSize-1:0] mem_addr;
    logic [wordSize-1:0] mem_wdata;
    logic [wordSize-1:0] mem_rdata;
    logic                mem_re;
    logic                mem_we;
    logic                mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one CPU read/write onto a ready-handshake RAM port with a bounded wait,
// and hands read words to the MDR with a one-cycle load strobe.
//
// state   | meaning
// IDLE    | no access, accepts rd_req (priority) or wr_req
// RD_WAIT | mem_re high, waiting for mem_ready or timeout
// RD_LOAD | word in rdata_q, MDR load strobe and done
// WR_WAIT | mem_we high, waiting for mem_ready or timeout
// WR_DONE | write acknowledged, done
// ERR     | memory never answered, err pulse
module mem_access_ctrl #(
    parameter int wordSize = 32,
    parameter int addrSize = 9,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [addrSize-1:0] addr,
    input  logic [wordSize-1:0] wdata,
    mem_access_ctrl_if.master   mem,
    output logic [wordSize-1:0] Mdatain,
    output logic                read,
    output logic                MDRin,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_LOAD = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [addrSize-1:0] addr_q;
    logic [wordSize-1:0] wdata_q;
    logic [wordSize-1:0] rdata_q;
    logic [7:0]          wait_cnt;
    logic                timed_out;

    assign timed_out = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    // mem_ready on the final wait cycle still completes the access
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_req)      state_nxt = RD_WAIT;
                else if (wr_req) state_nxt = WR_WAIT;
            end
            RD_WAIT: begin
                if (mem.mem_ready) state_nxt = RD_LOAD;
                else if (timed_out) state_nxt = ERR;
            end
            WR_WAIT: begin
                if (mem.mem_ready) state_nxt = WR_DONE;
                else if (timed_out) state_nxt = ERR;
            end
            RD_LOAD, WR_DONE, ERR: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        addr_q   <= addr;
                        wait_cnt <= '0;
                    end else if (wr_req) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        wait_cnt <= '0;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem.mem_ready) begin
                        if (state == RD_WAIT) rdata_q <= mem.mem_rdata;
                    end else if (!timed_out) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address/data buses reflect the capture registers at all times
    always_comb begin
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
        Mdatain       = rdata_q;
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        read          = 1'b0;
        MDRin         = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        busy          = (state != IDLE);
        case (state)
            RD_WAIT: mem.mem_re = 1'b1;
            WR_WAIT: mem.mem_we = 1'b1;
            RD_LOAD: begin
                read  = 1'b1;
                MDRin = 1'b1;
                done  = 1'b1;
            end
            WR_DONE: done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected done/err pulses into a
// scoreboard queue, a negedge monitor pops and compares whenever a pulse appears.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] Mdatain;
    logic        read, MDRin, busy, done, err;
    logic [31:0] mdr = '0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        done;
        logic        err;
        logic        mdrin;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    mem_access_ctrl_if mif ();

    mem_access_ctrl dut (
        .clk     (clk),
        .clr     (clr),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .addr    (addr),
        .wdata   (wdata),
        .mem     (mif),
        .Mdatain (Mdatain),
        .read    (read),
        .MDRin   (MDRin),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Downstream MDR: loads Mdatain when read-select and load strobe are both high
    always @(posedge clk) if (MDRin && read) mdr <= Mdatain;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic d, input logic e, input logic ld, input logic [31:0] data);
        exp_t x;
        x.done = d; x.err = e; x.mdrin = ld; x.rd = ld; x.data = data;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (done || err) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: got done=%b err=%b MDRin=%b, required no pulse",
                         done, err, MDRin);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({done, err, MDRin, read, Mdatain} !== {e.done, e.err, e.mdrin, e.rd, e.data}) begin
                    n_fail++;
                    $display("FAIL pulse: got done=%b err=%b MDRin=%b read=%b Mdatain=%h, required done=%b err=%b MDRin=%b read=%b Mdatain=%h",
                             done, err, MDRin, read, Mdatain, e.done, e.err, e.mdrin, e.rd, e.data);
                end
            end
        end
    end

    // One access; lat = wait cycle in which mem_ready is given (0 = never).
    // inj_k > 0 pulses wr_req with a stray address during that wait cycle.
    task automatic access(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] wd,
                          input int lat, input logic [31:0] rword, input int inj_k,
                          output int cycles);
        @(negedge clk);
        rd_req = rd; wr_req = wr; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0;
        cycles = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (!(mif.mem_re || mif.mem_we)) break;
            cycles++;
            chk("mem_re", mif.mem_re, rd);
            chk("mem_we", mif.mem_we, !rd);
            chk("mem_addr", mif.mem_addr, a);
            if (!rd) chk("mem_wdata", mif.mem_wdata, wd);
            if (k == lat) begin
                mif.mem_ready = 1'b1;
                mif.mem_rdata = rword;
            end
            if (k == inj_k) begin
                wr_req = 1'b1; addr = 9'h011; wdata = 32'h0;
            end
            @(posedge clk);
            #1;
            mif.mem_ready = 1'b0;
            mif.mem_rdata = 32'h0;
            wr_req = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mem_re", mif.mem_re, 0);
        chk("rst_mdatain", Mdatain, 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        push(1, 0, 1, 32'hDEADBEEF);
        access(1, 0, 9'h005, 32'h0, 1, 32'hDEADBEEF, 0, cyc);
        chk("rd0_wait_cycles", cyc, 1);
        @(negedge clk);
        chk("rd0_mdr", mdr, 32'hDEADBEEF);

        push(1, 0, 0, 32'hDEADBEEF);
        access(0, 1, 9'h1FF, 32'h12345678, 3, 32'h0, 0, cyc);
        chk("wr_wait_cycles", cyc, 3);

        push(0, 1, 0, 32'hDEADBEEF);
        access(1, 0, 9'h022, 32'h0, 0, 32'h0, 0, cyc);
        chk("timeout_wait_cycles", cyc, 15);

        push(1, 0, 1, 32'hA5A50F0F);
        access(1, 0, 9'h100, 32'h0, 15, 32'hA5A50F0F, 0, cyc);
        chk("boundary_wait_cycles", cyc, 15);
        @(negedge clk);
        chk("boundary_mdr", mdr, 32'hA5A50F0F);

        push(1, 0, 1, 32'h0BADF00D);
        access(1, 1, 9'h00C, 32'h00000055, 2, 32'h0BADF00D, 0, cyc);
        chk("collide_wait_cycles", cyc, 2);

        push(1, 0, 0, 32'h0BADF00D);
        access(0, 1, 9'h0AA, 32'hCAFEF00D, 4, 32'h0, 2, cyc);
        chk("busy_wr_wait_cycles", cyc, 4);
        repeat (3) @(negedge clk);
        chk("busy_wr_dropped", busy, 0);

        @(negedge clk);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        chk("idle_ready_busy", busy, 0);
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;

        @(negedge clk);
        rd_req = 1'b1; addr = 9'h033;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_re", mif.mem_re, 1);
        #2;
        clr = 1'b0;
        #1;
        chk("arst_mem_re", mif.mem_re, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mem_addr", mif.mem_addr, 0);
        chk("arst_mem_wdata", mif.mem_wdata, 0);
        chk("arst_mdatain", Mdatain, 0);
        chk("arst_strobes", {done, err, MDRin, read, mif.mem_we}, 0);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_mdatain", Mdatain, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
